// File: rtl/force_pe_to_cache_mapping_half_shell.sv
// Half-shell force return path: per-cell 14-slot buffer, round-robin drain to the force cache.
// Optional per-cell stall counter output enabled by `define FORCE_MAP_STALL_CNT_EN.
module force_pe_to_cache_mapping_half_shell #(
  parameter int unsigned NUM_CELLS          = 64,
  parameter int unsigned NUM_NEIGHBOR_CELLS = 13,
  parameter int unsigned FORCE_WIDTH        = 96,
  parameter int unsigned PID_WIDTH          = 8,
  parameter int unsigned X_DIM              = 4,
  parameter int unsigned Y_DIM              = 4,
  parameter int unsigned Z_DIM              = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [FORCE_WIDTH-1:0] pe_force [NUM_CELLS][NUM_NEIGHBOR_CELLS+1],
  input  logic [PID_WIDTH-1:0]   pe_pid   [NUM_CELLS][NUM_NEIGHBOR_CELLS+1],
  input  logic                   pe_valid [NUM_CELLS][NUM_NEIGHBOR_CELLS+1],
  output logic                   pe_ready [NUM_CELLS][NUM_NEIGHBOR_CELLS+1],
  output logic [FORCE_WIDTH-1:0] wr_force [NUM_CELLS],
  output logic [PID_WIDTH-1:0]   wr_pid   [NUM_CELLS],
  output logic [NUM_CELLS-1:0]   wr_valid,
  input  logic [NUM_CELLS-1:0]   wr_ready,
  output logic [NUM_CELLS-1:0]   cell_idle,
`ifdef FORCE_MAP_STALL_CNT_EN
  output logic [31:0]            stall_cnt [NUM_CELLS],
`endif
  output logic                   all_idle
);

  localparam int unsigned NUM_SLOTS = NUM_NEIGHBOR_CELLS + 1;
  localparam int unsigned SW        = $clog2(NUM_SLOTS);

  function automatic int off_x(int unsigned n);
    case (n)
      1, 4, 7, 10, 13: return 1;
      2, 5, 8, 11:     return -1;
      default:         return 0;
    endcase
  endfunction

  function automatic int off_y(int unsigned n);
    case (n)
      2, 3, 4, 11, 12, 13: return 1;
      5, 6, 7:             return -1;
      default:             return 0;
    endcase
  endfunction

  function automatic int off_z(int unsigned n);
    return (n >= 5) ? 1 : 0;
  endfunction

  // Source PE feeding dest cell c on slot n: c minus the slot offset, wrapping per axis.
  function automatic int unsigned src_cell(int unsigned c, int unsigned n);
    int x, y, z, sx, sy, sz;
    x  = int'(c % X_DIM);
    y  = int'((c / X_DIM) % Y_DIM);
    z  = int'(c / (X_DIM * Y_DIM));
    sx = (x - off_x(n) + int'(X_DIM)) % int'(X_DIM);
    sy = (y - off_y(n) + int'(Y_DIM)) % int'(Y_DIM);
    sz = (z - off_z(n) + int'(Z_DIM)) % int'(Z_DIM);
    return unsigned'(sz * int'(X_DIM * Y_DIM) + sy * int'(X_DIM) + sx);
  endfunction

  function automatic logic [SW-1:0] slot_add(logic [SW-1:0] a, int unsigned b);
    int unsigned s;
    s = 32'(a) + b;
    if (s >= NUM_SLOTS) s = s - NUM_SLOTS;
    return SW'(s);
  endfunction

  for (genvar c = 0; c < NUM_CELLS; c++) begin : g_cell
    logic [NUM_SLOTS-1:0]   in_valid, slot_ready, accept, drain, full_q, full_d;
    logic [FORCE_WIDTH-1:0] in_force [NUM_SLOTS];
    logic [PID_WIDTH-1:0]   in_pid   [NUM_SLOTS];
    logic [FORCE_WIDTH-1:0] force_q  [NUM_SLOTS];
    logic [FORCE_WIDTH-1:0] force_d  [NUM_SLOTS];
    logic [PID_WIDTH-1:0]   pid_q    [NUM_SLOTS];
    logic [PID_WIDTH-1:0]   pid_d    [NUM_SLOTS];
    logic [SW-1:0]          ptr_q, ptr_d, grant;
    logic                   found, handshake;

    for (genvar n = 0; n < NUM_SLOTS; n++) begin : g_slot
      localparam int unsigned Src = src_cell(c, n);
      assign in_valid[n]      = pe_valid[Src][n];
      assign in_force[n]      = pe_force[Src][n];
      assign in_pid[n]        = pe_pid[Src][n];
      assign pe_ready[Src][n] = slot_ready[n];
    end

    always_comb begin
      grant = ptr_q;
      found = 1'b0;
      for (int unsigned i = 0; i < NUM_SLOTS; i++) begin
        if (!found && full_q[slot_add(ptr_q, i)]) begin
          grant = slot_add(ptr_q, i);
          found = 1'b1;
        end
      end
      handshake = (|full_q) & wr_ready[c];
      drain     = '0;
      if (handshake) drain[grant] = 1'b1;
      slot_ready = ~full_q | drain;
      accept     = in_valid & slot_ready;
      full_d     = (full_q & ~drain) | accept;
      for (int unsigned n = 0; n < NUM_SLOTS; n++) begin
        force_d[n] = accept[n] ? in_force[n] : force_q[n];
        pid_d[n]   = accept[n] ? in_pid[n] : pid_q[n];
      end
      // Parking ptr on a stalled grant keeps it the winner until the cache accepts it,
      // even if an earlier slot fills in the meantime.
      ptr_d = ptr_q;
      if (handshake)    ptr_d = slot_add(grant, 1);
      else if (|full_q) ptr_d = grant;
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        full_q <= '0;
        ptr_q  <= '0;
        for (int unsigned n = 0; n < NUM_SLOTS; n++) begin
          force_q[n] <= '0;
          pid_q[n]   <= '0;
        end
      end else begin
        full_q <= full_d;
        ptr_q  <= ptr_d;
        for (int unsigned n = 0; n < NUM_SLOTS; n++) begin
          force_q[n] <= force_d[n];
          pid_q[n]   <= pid_d[n];
        end
      end
    end

    assign wr_valid[c]  = |full_q;
    assign wr_force[c]  = force_q[grant];
    assign wr_pid[c]    = pid_q[grant];
    assign cell_idle[c] = ~|full_q;

`ifdef FORCE_MAP_STALL_CNT_EN
    logic [31:0] stall_q, stall_d;

    always_comb begin
      stall_d = stall_q;
      if ((|full_q) && !wr_ready[c] && !(&stall_q)) stall_d = stall_q + 32'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) stall_q <= '0;
      else        stall_q <= stall_d;
    end

    assign stall_cnt[c] = stall_q;
`endif
  end

  assign all_idle = &cell_idle;

endmodule

// File: tb/tb_force_pe_to_cache_mapping_half_shell.sv
// Scoreboarded bench for the half-shell force return path (4x4x4 grid).
module tb_force_pe_to_cache_mapping_half_shell;
  localparam int NC = 64;
  localparam int NS = 14;
  localparam int FW = 96;
  localparam int PW = 8;
  localparam int XD = 4;
  localparam int YD = 4;
  localparam int ZD = 4;
  localparam int DX [NS] = '{0, 1, -1, 0, 1, -1, 0, 1, -1, 0, 1, -1, 0, 1};
  localparam int DY [NS] = '{0, 0, 1, 1, 1, -1, -1, -1, 0, 0, 0, 1, 1, 1};
  localparam int DZ [NS] = '{0, 0, 0, 0, 0, 1, 1, 1, 1, 1, 1, 1, 1, 1};

  typedef logic [PW+FW-1:0] beat_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [FW-1:0] pe_force [NC][NS];
  logic [PW-1:0] pe_pid   [NC][NS];
  logic          pe_valid [NC][NS];
  logic          pe_ready [NC][NS];
  logic [FW-1:0] wr_force [NC];
  logic [PW-1:0] wr_pid   [NC];
  logic [NC-1:0] wr_valid;
  logic [NC-1:0] wr_ready;
  logic [NC-1:0] cell_idle;
  logic          all_idle;
`ifdef FORCE_MAP_STALL_CNT_EN
  logic [31:0]   stall_cnt [NC];
`endif

  beat_t exp_q [NC][NS][$];
  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  force_pe_to_cache_mapping_half_shell dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .pe_force  (pe_force),
    .pe_pid    (pe_pid),
    .pe_valid  (pe_valid),
    .pe_ready  (pe_ready),
    .wr_force  (wr_force),
    .wr_pid    (wr_pid),
    .wr_valid  (wr_valid),
    .wr_ready  (wr_ready),
    .cell_idle (cell_idle),
`ifdef FORCE_MAP_STALL_CNT_EN
    .stall_cnt (stall_cnt),
`endif
    .all_idle  (all_idle)
  );

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic int dest_of(int h, int n);
    int x, y, z;
    x = h % XD;
    y = (h / XD) % YD;
    z = h / (XD * YD);
    return ((z + DZ[n] + ZD) % ZD) * XD * YD + ((y + DY[n] + YD) % YD) * XD + (x + DX[n] + XD) % XD;
  endfunction

  function automatic int src_for(int c, int n);
    for (int h = 0; h < NC; h++) if (dest_of(h, n) == c) return h;
    return 0;
  endfunction

  function automatic logic [FW-1:0] mk_force(int d, int n, logic [15:0] seq);
    logic [7:0] d8, n8;
    d8 = 8'(d);
    n8 = 8'(n);
    return {64'hA5A5_A5A5_A5A5_A5A5, seq, d8, n8};
  endfunction

  task automatic fire(input int h, input int n, input logic [PW-1:0] pid, input logic [15:0] seq);
    pe_valid[h][n] = 1'b1;
    pe_pid[h][n]   = pid;
    pe_force[h][n] = mk_force(dest_of(h, n), n, seq);
  endtask

  task automatic clear_valid();
    for (int h = 0; h < NC; h++) for (int n = 0; n < NS; n++) pe_valid[h][n] = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int ready_zeros();
    int z = 0;
    for (int h = 0; h < NC; h++) for (int n = 0; n < NS; n++) if (pe_ready[h][n] !== 1'b1) z++;
    return z;
  endfunction

  // Pops on each beat about to transfer, pushes each contribution about to be accepted.
  always @(negedge clk) begin
    int    s;
    beat_t e;
    if (rst_n) begin
      for (int c = 0; c < NC; c++) begin
        if (wr_valid[c] && wr_ready[c]) begin
          s = int'(wr_force[c][7:0]);
          if (s >= NS || exp_q[c][s].size() == 0) begin
            check($sformatf("spurious_beat_c%0d", c), 128'(wr_valid[c]), 128'd0);
          end else begin
            e = exp_q[c][s].pop_front();
            check($sformatf("beat_c%0d_s%0d", c, s), 128'({wr_pid[c], wr_force[c]}), 128'(e));
          end
        end
      end
      for (int h = 0; h < NC; h++) begin
        for (int n = 0; n < NS; n++) begin
          if (pe_valid[h][n] && pe_ready[h][n])
            exp_q[dest_of(h, n)][n].push_back({pe_pid[h][n], pe_force[h][n]});
        end
      end
    end
  end

  initial begin
    int h;
    int left;
    logic [FW-1:0] held;
    for (int i = 0; i < NC; i++) begin
      for (int n = 0; n < NS; n++) begin
        pe_valid[i][n] = 1'b0;
        pe_force[i][n] = '0;
        pe_pid[i][n]   = '0;
      end
    end
    wr_ready = '1;
    #2;
    check("rst_wr_valid", 128'(wr_valid), 128'd0);
    check("rst_pe_ready_zeros", 128'(ready_zeros()), 128'd0);
    check("rst_cell_idle", 128'(cell_idle), 128'(64'hFFFF_FFFF_FFFF_FFFF));
    check("rst_all_idle", 128'(all_idle), 128'd1);
    check("rst_wr_force0", 128'(wr_force[0]), 128'd0);
    tick(); tick(); tick();
    rst_n = 1'b1;
    tick();

    // PE 63 (3,3,3) slot 13 wraps to cell 0
    fire(63, 13, 8'd7, 16'hA5A5);
    tick();
    clear_valid();
    check("t1_wr_valid", 128'(wr_valid), 128'(64'h1));
    check("t1_wr_force", 128'(wr_force[0]), 128'(mk_force(0, 13, 16'hA5A5)));
    check("t1_wr_pid", 128'(wr_pid[0]), 128'd7);
    tick();
    check("t1_idle", 128'(all_idle), 128'd1);

    // PE 0 slot 5 lands on cell 31 = (3,3,1)
    fire(0, 5, 8'd3, 16'h0001);
    tick();
    clear_valid();
    check("t2_wr_valid", 128'(wr_valid), 128'(64'h1) << 31);
    tick();

    // All 14 sources of cell 0 at once; drain order follows slot index
    for (int i = 0; i < NC; i++)
      for (int n = 0; n < NS; n++)
        if (dest_of(i, n) == 0) fire(i, n, 8'(n + 16), 16'h0100);
    tick();
    clear_valid();
    for (int k = 0; k < NS; k++) begin
      check($sformatf("t3_valid_k%0d", k), 128'(wr_valid[0]), 128'd1);
      check($sformatf("t3_order_k%0d", k), 128'(wr_force[0][7:0]), 128'(k));
      tick();
    end
    check("t3_cell_idle0", 128'(cell_idle[0]), 128'd1);
    check("t3_all_idle", 128'(all_idle), 128'd1);

    // Backpressure on cell 5 slot 3; slot 1 fills mid-stall and must not steal the grant
    h = src_for(5, 3);
    wr_ready[5] = 1'b0;
    fire(h, 3, 8'd55, 16'h0500);
    held = mk_force(5, 3, 16'h0500);
    tick();
    for (int i = 1; i <= 10; i++) begin
      clear_valid();
      if (i == 2) fire(src_for(5, 1), 1, 8'd51, 16'h0501);
      check($sformatf("t4_pe_ready_i%0d", i), 128'(pe_ready[h][3]), 128'd0);
      check($sformatf("t4_valid_i%0d", i), 128'(wr_valid[5]), 128'd1);
      check($sformatf("t4_stable_i%0d", i), 128'(wr_force[5]), 128'(held));
      tick();
    end
    clear_valid();
`ifdef FORCE_MAP_STALL_CNT_EN
    check("t4_stall_cnt", 128'(stall_cnt[5]), 128'd10);
`endif
    wr_ready[5] = 1'b1;
    tick(); tick(); tick();
    check("t4_cell_idle5", 128'(cell_idle[5]), 128'd1);

    // Same-cycle drain and refill of cell 9 slot 2 gives gapless beats
    h = src_for(9, 2);
    fire(h, 2, 8'd90, 16'h0900);
    tick();
    for (int k = 1; k <= 4; k++) begin
      fire(h, 2, 8'(90 + k), 16'(16'h0900 + k));
      check($sformatf("t5_pe_ready_k%0d", k), 128'(pe_ready[h][2]), 128'd1);
      tick();
      check($sformatf("t5_no_bubble_k%0d", k), 128'(wr_valid[9]), 128'd1);
    end
    clear_valid();
    tick();
    check("t5_cell_idle9", 128'(cell_idle[9]), 128'd1);

    // Reset while six slots of cell 0 are held full
    wr_ready[0] = 1'b0;
    for (int n = 0; n < 6; n++) fire(src_for(0, n), n, 8'(n), 16'h0A00);
    tick();
    clear_valid();
    check("t6_pre_valid", 128'(wr_valid[0]), 128'd1);
    rst_n = 1'b0;
    #1;
    check("t6_rst_wr_valid", 128'(wr_valid), 128'd0);
    check("t6_rst_pe_ready_zeros", 128'(ready_zeros()), 128'd0);
    check("t6_rst_all_idle", 128'(all_idle), 128'd1);
    check("t6_rst_wr_force0", 128'(wr_force[0]), 128'd0);
`ifdef FORCE_MAP_STALL_CNT_EN
    check("t6_rst_stall_cnt5", 128'(stall_cnt[5]), 128'd0);
`endif
    for (int c = 0; c < NC; c++) for (int n = 0; n < NS; n++) exp_q[c][n].delete();
    tick(); tick();
    wr_ready = '1;
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      check($sformatf("t6_no_stale_i%0d", i), 128'(wr_valid), 128'd0);
      tick();
    end

    left = 0;
    for (int c = 0; c < NC; c++) for (int n = 0; n < NS; n++) left += exp_q[c][n].size();
    check("sb_empty", 128'(left), 128'd0);
    check("final_all_idle", 128'(all_idle), 128'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
